// File: rtl/pacman_pkg.sv
// pacman_pkg
//   Shared types for the game step logic.
//   dir_t        : keyboard / movement direction (0 up, 1 down, 2 left, 3 right)
//   step_state_t : phases of one game step in game_step_sequencer
//   idx_width()  : index width for a set of n items, never narrower than 1 bit
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_PAC   = 3'd2,
    ST_GHOST = 3'd3,
    ST_COLL  = 3'd4,
    ST_DONE  = 3'd5
  } step_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_step_sequencer.sv
// game_step_sequencer
//   Runs one game step per step_tick: snapshot direction, move Pac-Man, move each
//   ghost in turn, then check for a collision. Every phase is a req/done handshake
//   guarded by a watchdog so a stuck datapath block cannot freeze the game.
// Ports
//   Clk, Reset               clock, asynchronous active-high reset
//   step_tick, pause         step request pulse; level that holds off new steps
//   dir_in, dir_valid        keyboard direction and its qualifier
//   step_dir                 direction snapshot for the current step
//   pac_req/pac_done         Pac-Man move handshake
//   ghost_req/ghost_idx/ghost_done  ghost move handshake, one per ghost
//   coll_req/coll_done/collision    collision check handshake and result
//   death                    one-cycle pulse when a step ends in a collision
//   busy                     a step is in progress
//   step_count               completed steps (wrapping)
//   overrun, timeout_err     sticky error flags, cleared by clr_err
module game_step_sequencer
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STEP_CNT_W     = 16
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               step_tick,
  input  logic                               pause,
  input  logic [1:0]                         dir_in,
  input  logic                               dir_valid,
  output logic [1:0]                         step_dir,
  output logic                               pac_req,
  input  logic                               pac_done,
  output logic                               ghost_req,
  output logic [idx_width(NUM_GHOSTS)-1:0]   ghost_idx,
  input  logic                               ghost_done,
  output logic                               coll_req,
  input  logic                               coll_done,
  input  logic                               collision,
  output logic                               death,
  output logic                               busy,
  output logic [STEP_CNT_W-1:0]              step_count,
  output logic                               overrun,
  output logic                               timeout_err,
  input  logic                               clr_err
);

  localparam int GI_W = idx_width(NUM_GHOSTS);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [GI_W-1:0] LAST_GHOST = GI_W'(NUM_GHOSTS - 1);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 1);

  step_state_t             state_r;
  step_state_t             state_s;
  dir_t                    dir_reg_r;
  dir_t                    step_dir_r;
  logic                    pending_r;
  logic                    coll_hit_r;
  logic [WD_W-1:0]         wd_r;
  logic [GI_W-1:0]         ghost_idx_r;
  logic [STEP_CNT_W-1:0]   step_count_r;
  logic                    overrun_r;
  logic                    timeout_r;

  logic req_active_s;
  logic phase_done_s;
  logic wd_expired_s;
  logic advance_s;
  logic timeout_set_s;
  logic overrun_set_s;
  logic start_s;

  // Handshake bookkeeping shared by the three request phases
  always_comb begin
    phase_done_s = 1'b0;
    case (state_r)
      ST_PAC:   phase_done_s = pac_done;
      ST_GHOST: phase_done_s = ghost_done;
      ST_COLL:  phase_done_s = coll_done;
      default:  phase_done_s = 1'b0;
    endcase
    req_active_s  = (state_r == ST_PAC) || (state_r == ST_GHOST) || (state_r == ST_COLL);
    wd_expired_s  = req_active_s && (wd_r == WD_LIMIT);
    // A watchdog expiry is treated exactly like the missing done
    advance_s     = req_active_s && (phase_done_s || wd_expired_s);
    timeout_set_s = wd_expired_s && !phase_done_s;
    start_s       = (state_r == ST_IDLE) && (step_tick || pending_r) && !pause;
    // A tick while busy is lost only if one step is already queued
    overrun_set_s = (state_r != ST_IDLE) && step_tick && pending_r;
  end

  // Next-state decode of the step sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s) state_s = ST_LATCH; else state_s = ST_IDLE;
      ST_LATCH: state_s = ST_PAC;
      ST_PAC:   if (advance_s) state_s = ST_GHOST; else state_s = ST_PAC;
      ST_GHOST: if (advance_s && (ghost_idx_r == LAST_GHOST)) state_s = ST_COLL;
                else state_s = ST_GHOST;
      ST_COLL:  if (advance_s) state_s = ST_DONE; else state_s = ST_COLL;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Watchdog: restarts on every phase or ghost entry, counts while a req is up
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                          wd_r <= '0;
    else if (!req_active_s || advance_s) wd_r <= '0;
    else                                wd_r <= wd_r + WD_W'(1);
  end

  // Direction capture, step snapshot, ghost index, collision result, step counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dir_reg_r    <= DIR_UP;
      step_dir_r   <= DIR_UP;
      ghost_idx_r  <= '0;
      coll_hit_r   <= 1'b0;
      step_count_r <= '0;
    end else begin
      if (dir_valid) dir_reg_r <= dir_t'(dir_in);
      if (state_r == ST_LATCH) begin
        // Same-cycle dir_valid wins over the held direction
        step_dir_r  <= dir_valid ? dir_t'(dir_in) : dir_reg_r;
        ghost_idx_r <= '0;
      end
      if ((state_r == ST_GHOST) && advance_s && (ghost_idx_r != LAST_GHOST))
        ghost_idx_r <= ghost_idx_r + GI_W'(1);
      // A timed-out collision check never reports a hit
      if ((state_r == ST_COLL) && advance_s) coll_hit_r <= coll_done & collision;
      if (state_r == ST_DONE) step_count_r <= step_count_r + STEP_CNT_W'(1);
    end
  end

  // Single-entry step queue and sticky error flags (a set beats a clear)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (start_s)
        pending_r <= 1'b0;
      else if ((state_r != ST_IDLE) && step_tick)
        pending_r <= 1'b1;
      if (overrun_set_s) overrun_r <= 1'b1;
      else if (clr_err)  overrun_r <= 1'b0;
      if (timeout_set_s) timeout_r <= 1'b1;
      else if (clr_err)  timeout_r <= 1'b0;
    end
  end

  assign pac_req     = (state_r == ST_PAC);
  assign ghost_req   = (state_r == ST_GHOST);
  assign coll_req    = (state_r == ST_COLL);
  assign busy        = (state_r != ST_IDLE);
  assign death       = (state_r == ST_DONE) && coll_hit_r;
  assign step_dir    = step_dir_r;
  assign ghost_idx   = ghost_idx_r;
  assign step_count  = step_count_r;
  assign overrun     = overrun_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_game_step_sequencer.sv
// tb_game_step_sequencer
//   Scoreboard bench: the stimulus process pushes the expected result of every
//   step it launches (direction snapshot, death, running step count); a monitor
//   pops and compares whenever step_count moves. A responder process answers
//   the req/done handshakes with random latency and checks ghost ordering.
module tb_game_step_sequencer;

  localparam int NG  = 4;
  localparam int TO  = 16;
  localparam int SCW = 16;

  typedef struct {
    logic [1:0]     dir;
    logic           death;
    logic [SCW-1:0] count;
  } exp_t;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           step_tick, pause, dir_valid, clr_err;
  logic [1:0]     dir_in;
  logic [1:0]     step_dir;
  logic           pac_req, pac_done, ghost_req, ghost_done, coll_req, coll_done, collision;
  logic [1:0]     ghost_idx;
  logic           death, busy, overrun, timeout_err;
  logic [SCW-1:0] step_count;

  game_step_sequencer #(.NUM_GHOSTS(NG), .TIMEOUT_CYCLES(TO), .STEP_CNT_W(SCW)) dut (
    .Clk(Clk), .Reset(Reset), .step_tick(step_tick), .pause(pause),
    .dir_in(dir_in), .dir_valid(dir_valid), .step_dir(step_dir),
    .pac_req(pac_req), .pac_done(pac_done), .ghost_req(ghost_req),
    .ghost_idx(ghost_idx), .ghost_done(ghost_done), .coll_req(coll_req),
    .coll_done(coll_done), .collision(collision), .death(death), .busy(busy),
    .step_count(step_count), .overrun(overrun), .timeout_err(timeout_err),
    .clr_err(clr_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // reference model state
  logic [1:0]     model_dir   = 2'd0;
  logic [SCW-1:0] model_count = '0;

  // responder controls
  bit pac_block  = 1'b0;
  bit coll_block = 1'b0;
  bit cur_coll   = 1'b0;
  int dmax       = 0;
  int exp_ghost  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder: answers each req after a random number of cycles
  initial begin
    int wcnt = 0;
    int wlim = 0;
    pac_done = 1'b0; ghost_done = 1'b0; coll_done = 1'b0; collision = 1'b0;
    forever begin
      @(negedge Clk);
      pac_done = 1'b0; ghost_done = 1'b0; coll_done = 1'b0; collision = 1'b0;
      if (Reset === 1'b1) begin
        wcnt = 0; exp_ghost = 0;
      end else if (pac_req || ghost_req || coll_req) begin
        if (pac_req) exp_ghost = 0;
        if (wcnt >= wlim && !(pac_req && pac_block) && !(coll_req && coll_block)) begin
          if (pac_req) pac_done = 1'b1;
          else if (ghost_req) begin
            chk("ghost_idx_order", 32'(ghost_idx), 32'(exp_ghost));
            exp_ghost++;
            ghost_done = 1'b1;
          end else begin
            coll_done = 1'b1;
            collision = cur_coll;
          end
          wcnt = 0;
          wlim = $urandom_range(dmax, 0);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: a step_count change marks a completed step; compare against the queue
  initial begin
    logic [SCW-1:0] prev_count = '0;
    logic           prev_death = 1'b0;
    logic [1:0]     prev_dir   = 2'd0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset !== 1'b0) begin
        prev_count = step_count; prev_death = 1'b0; prev_dir = 2'd0;
      end else begin
        if (step_count !== prev_count) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_step: got count %0d expected no step", step_count);
          end else begin
            e = sb_q.pop_front();
            chk("step_count", 32'(step_count), 32'(e.count));
            chk("death", 32'(prev_death), 32'(e.death));
            chk("step_dir", 32'(prev_dir), 32'(e.dir));
            chk("ghosts_moved", 32'(exp_ghost), 32'(NG));
          end
        end
        prev_count = step_count; prev_death = death; prev_dir = step_dir;
      end
    end
  end

  task automatic drive(input bit t, input bit dv, input logic [1:0] d);
    @(negedge Clk);
    step_tick = t; dir_valid = dv; dir_in = d;
    if (dv) model_dir = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0);
  endtask

  task automatic push_step(input bit d_exp);
    exp_t e;
    model_count = model_count + SCW'(1);
    e.dir = model_dir; e.death = d_exp; e.count = model_count;
    sb_q.push_back(e);
  endtask

  // Tick from IDLE; the snapshot is taken on the cycle after the tick
  task automatic issue(input bit d_exp, input bit rnd);
    drive(1'b1, rnd ? 1'($urandom_range(1, 0)) : 1'b0, 2'($urandom_range(3, 0)));
    drive(1'b0, rnd ? 1'($urandom_range(1, 0)) : 1'b0, 2'($urandom_range(3, 0)));
    push_step(d_exp);
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 3000) begin
      drive(1'b0, rnd ? 1'($urandom_range(1, 0)) : 1'b0, 2'($urandom_range(3, 0)));
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s: step did not complete within 3000 cycles, %0d outstanding", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic clear_errs();
    @(negedge Clk);
    clr_err = 1'b1;
    @(negedge Clk);
    clr_err = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1'b1; step_tick = 1'b0; pause = 1'b0; dir_valid = 1'b0;
    dir_in = 2'd0; clr_err = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        {16'd0, step_dir, pac_req, ghost_req, ghost_idx, coll_req, death, busy, overrun, timeout_err},
        32'd0);
    chk("reset_count", 32'(step_count), 32'd0);
    #2 Reset = 1'b0;

    // 1: basic step, immediate dones, latency and length
    dmax = 0; cur_coll = 1'b0;
    idle(2);
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0);
    push_step(1'b0);
    chk("latch_no_req", {30'd0, pac_req, busy}, 32'd1);
    drive(1'b0, 1'b0, 2'd0);
    chk("pac_req_n_plus_2", 32'(pac_req), 32'd1);
    n = 2;
    while (busy && n < 50) begin drive(1'b0, 1'b0, 2'd0); if (busy) n++; end
    chk("busy_cycles", 32'(n), 32'(4 + NG));
    idle(2);
    chk("count_after_1", 32'(step_count), 32'd1);

    // 2: direction snapshot ignores changes during the step
    drive(1'b0, 1'b1, 2'd2);
    idle(1);
    issue(1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd3);
    chk("dir_held_in_pac", 32'(step_dir), 32'd2);
    wait_done("t2", 1'b0);

    // 3: two ticks mid-step -> one queued step plus overrun
    issue(1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0);
    push_step(1'b0);
    drive(1'b0, 1'b0, 2'd0);
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_done("t3", 1'b0);
    idle(3);
    chk("no_third_step", 32'(busy), 32'd0);
    clear_errs();
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // 4: Pac-Man phase times out and the step carries on
    pac_block = 1'b1;
    issue(1'b0, 1'b0);
    n = 0;
    drive(1'b0, 1'b0, 2'd0);
    while (pac_req && n < 100) begin n++; drive(1'b0, 1'b0, 2'd0); end
    chk("pac_timeout_len", 32'(n), 32'(TO));
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("ghost_after_timeout", 32'(ghost_req), 32'd1);
    pac_block = 1'b0;
    wait_done("t4", 1'b0);
    clear_errs();
    chk("timeout_cleared", 32'(timeout_err), 32'd0);
    // collision phase timeout reports no hit
    coll_block = 1'b1; cur_coll = 1'b1;
    issue(1'b0, 1'b0);
    wait_done("t4c", 1'b0);
    coll_block = 1'b0;
    chk("coll_timeout_err", 32'(timeout_err), 32'd1);
    clear_errs();

    // 5: collision -> one-cycle death pulse; pause behaviour
    issue(1'b1, 1'b0);
    n = 0;
    while (busy && n < 200) begin if (death) n++; drive(1'b0, 1'b0, 2'd0); end
    if (death) n++;
    chk("death_cycles", 32'(n), 32'd1);
    wait_done("t5", 1'b0);
    cur_coll = 1'b0;
    pause = 1'b1;
    drive(1'b1, 1'b0, 2'd0);
    idle(10);
    chk("paused_no_start", 32'(busy), 32'd0);
    pause = 1'b0;
    idle(5);
    chk("paused_tick_dropped", 32'(busy), 32'd0);
    // pause mid-step holds the queued step until pause drops
    issue(1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0);
    pause = 1'b1;
    push_step(1'b0);
    n = 0;
    while (busy && n < 200) begin drive(1'b0, 1'b0, 2'd0); n++; end
    idle(5);
    chk("pending_held", {31'd0, busy}, 32'd0);
    chk("queued_outstanding", 32'(sb_q.size()), 32'd1);
    pause = 1'b0;
    wait_done("t5p", 1'b0);

    // random steps
    for (int k = 0; k < 30; k++) begin
      dmax = $urandom_range(3, 0);
      cur_coll = 1'($urandom_range(1, 0));
      issue(cur_coll, 1'b1);
      wait_done("rand", 1'b1);
      idle($urandom_range(3, 0));
    end
    chk("flags_clean", {30'd0, overrun, timeout_err}, 32'd0);

    // 6: reset in GHOST
    dmax = 2;
    issue(1'b0, 1'b0);
    n = 0;
    while (!ghost_req && n < 50) begin drive(1'b0, 1'b0, 2'd0); n++; end
    chk("reached_ghost", 32'(ghost_req), 32'd1);
    #2 Reset = 1'b1;
    #1 chk("async_reset_reqs", {29'd0, pac_req, ghost_req, coll_req}, 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    sb_q.delete(); model_count = '0; model_dir = 2'd0;
    @(negedge Clk);
    #2 Reset = 1'b0;
    idle(2);
    chk("post_reset_count", 32'(step_count), 32'd0);
    chk("post_reset_idle", 32'(busy), 32'd0);
    issue(1'b0, 1'b1);
    wait_done("t6", 1'b1);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
